// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (pixel divider, x/y counters, syncs, line/frame pulses).
// Define VGA_TIMING_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CLK_DIV    = 2,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 10,
    parameter int FRAME_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               p_tick,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (CLK_DIV < 1 || H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] nx;
    logic [CNT_W-1:0] ny;
    logic             wrap_frame;

    // pixel enable and the coordinates the next pixel tick will load
    always_comb begin
        p_tick     = en && (div_cnt == DIV_LAST);
        nx         = (x == H_LAST) ? '0 : x + 1'b1;
        ny         = (x == H_LAST) ? ((y == V_LAST) ? '0 : y + 1'b1) : y;
        wrap_frame = p_tick && (nx == '0) && (ny == '0);
    end

    // divider, counters and decodes of the next x/y so outputs stay coherent with x/y
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt     <= '0;
            x           <= H_LAST;
            y           <= V_LAST;
            video_on    <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= p_tick && (nx == '0);
            frame_start <= wrap_frame;
            if (p_tick) begin
                div_cnt  <= '0;
                x        <= nx;
                y        <= ny;
                video_on <= (nx < H_VIS) && (ny < V_VIS);
                hsync    <= (nx >= HS_FIRST && nx <= HS_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
                vsync    <= (ny >= VS_FIRST && ny <= VS_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
            end else if (en) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // completed-frame counter, bumped together with frame_start
    always_ff @(posedge clk) begin
        if (!reset)
            frame_count <= '0;
        else if (wrap_frame)
            frame_count <= frame_count + 1'b1;
    end
`else
    assign frame_count = '0;
`endif
endmodule
